snow64_mem_access_arbiter: RTL and testbench
============================================

// Module: snow64_mem_access_arbiter
// PURPOSE
//  Parametrised N-channel arbiter: merges per-channel CPU memory requests (req/addr/data/acc_type) onto one memory port.
//  Returns each response (valid/data) to the granted channel only. Round-robin fairness and a response watchdog.
//  Sits between LAR-file/fetch clients and the single external memory interface; one transaction in flight at a time.
// PARAMETERS
//  NUM_PORTS      4    requesting channels (>=2); grant index width GW = $clog2(NUM_PORTS)
//  ADDR_WIDTH     64   address bits per request
//  DATA_WIDTH     256  data bits per request/response (one LAR line)
//  TIMEOUT_CYCLES 0    max WAIT cycles before error; 0 disables watchdog
// PORTS
//  clk               in   1             rising-edge clock
//  rst_n             in   1             asynchronous active-low reset
//  in_req            in   NUM_PORTS     per-channel level request; held until that channel's out_valid
//  in_addr           in   NUM_PORTS*AW  channel c at [c*AW +: AW]
//  in_data           in   NUM_PORTS*DW  write data, channel c at [c*DW +: DW]
//  in_mem_acc_type   in   NUM_PORTS     0 = read, 1 = write
//  out_valid         out  NUM_PORTS     one-hot response pulse to granted channel
//  out_err           out  NUM_PORTS     one-hot, set with out_valid on watchdog expiry
//  out_data          out  DW            response data (shared; qualified by out_valid)
//  out_mem_req       out  1             one-cycle request pulse to memory
//  out_mem_addr      out  AW            latched address
//  out_mem_data      out  DW            latched write data
//  out_mem_acc_type  out  1             latched access type
//  in_mem_valid      in   1             memory response strobe
//  in_mem_data       in   DW            memory response data
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; rr_last = NUM_PORTS-1 (channel 0 has first priority); watchdog counter 0.
//  FSM states:
//   IDLE : in_req sampled only here; a grant exists if any bit is set.
//   ISSUE: exactly one cycle.
//   WAIT : holds for the response or watchdog expiry.
//   DONE : exactly one cycle.
//  IDLE:  if any in_req, grant = first set index searching (rr_last+1) mod N upward with wrap.
//         Latch addr/data/acc_type of grant; -> ISSUE. Else stay.
//  ISSUE: out_mem_req=1 for this cycle only; addr/data/type stay stable from ISSUE through DONE; -> WAIT.
//         in_mem_valid in ISSUE is ignored: memory shall respond no earlier than the cycle after out_mem_req.
//  WAIT:  on in_mem_valid, capture in_mem_data into out_data; -> DONE.
//         If TIMEOUT_CYCLES>0 and the counter reaches TIMEOUT_CYCLES with no valid: out_data=0, set error flag, -> DONE.
//         Counter clears on entry to WAIT and saturates; a valid and expiry in the same cycle counts as valid (no error).
//  DONE:  out_valid[grant]=1, out_err[grant]=error flag; rr_last<=grant; -> IDLE. Error flag clears in IDLE.
//         Requester shall drop in_req at the edge ending DONE; if still high in IDLE, it is a new request.
//  Min latency: req seen in IDLE cycle 0, mem_req cycle 1, mem_valid cycle 2, out_valid cycle 3.
//  Throughput: one transaction per 4 cycles best case.
//  Writes use the same handshake: memory must still strobe in_mem_valid; out_data captures in_mem_data unchanged.
//  in_mem_valid outside WAIT is ignored (stale responses after reset or timeout are dropped).
//  A channel dropping in_req while granted does not abort the transaction; the response is still pulsed.
//  Reset mid-transaction: immediate return to reset values, no out_valid emitted for the aborted grant.
// TESTING
//  1 Read ch2 addr 0x1000, mem_valid 1 cycle after mem_req, data 0xAB repeated
//    -> mem_addr=0x1000, acc_type=0, out_valid=4'b0100 at cycle 3, out_data=0xAB..AB, out_err=0.
//  2 All 4 channels hold req for 16 transactions -> grant order 0,1,2,3,0,1,... with no channel skipped or repeated.
//  3 After a grant to ch1, ch1 and ch3 both request -> ch3 served first, then ch1.
//  4 TIMEOUT_CYCLES=8, ch0 read, no mem_valid -> out_valid[0]=out_err[0]=1 at cycle 11, out_data=0.
//    A later stray mem_valid is ignored.
//  5 rst_n low in WAIT for ch1, mem_valid arrives after rst_n rises -> all outputs 0, no out_valid, next req from ch0 served normally.
//  6 Write ch3 addr 0x40, data 0x5A.. -> mem_acc_type=1, mem_data=0x5A.., out_valid[3] after mem_valid; same-cycle valid+expiry -> out_err=0.

Source files
------------

// File: rtl/snow64_mem_access_arbiter.sv
// Round-robin arbiter funnelling N channel requests onto one memory port,
// with a single transaction in flight and an optional response watchdog.
module snow64_mem_access_arbiter #(
    parameter int NUM_PORTS      = 4,
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 256,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_PORTS-1:0]            in_req,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] in_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_PORTS-1:0]            in_mem_acc_type,
    output logic [NUM_PORTS-1:0]            out_valid,
    output logic [NUM_PORTS-1:0]            out_err,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic                            out_mem_req,
    output logic [ADDR_WIDTH-1:0]           out_mem_addr,
    output logic [DATA_WIDTH-1:0]           out_mem_data,
    output logic                            out_mem_acc_type,
    input  logic                            in_mem_valid,
    input  logic [DATA_WIDTH-1:0]           in_mem_data
);

    localparam int GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT_CYCLES);
    localparam logic [GW-1:0] RR_RESET = GW'(NUM_PORTS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                state_q;
    logic [GW-1:0]         rr_last_q;
    logic [GW-1:0]         grant_q;
    logic [CW-1:0]         cnt_q;
    logic [CW-1:0]         cnt_d;
    logic [NUM_PORTS-1:0]  out_valid_q;
    logic [NUM_PORTS-1:0]  out_err_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic                  out_mem_req_q;
    logic [ADDR_WIDTH-1:0] out_mem_addr_q;
    logic [DATA_WIDTH-1:0] out_mem_data_q;
    logic                  out_mem_acc_type_q;

    logic [GW-1:0]         idx_s;
    logic [GW-1:0]         grant_s;
    logic                  grant_vld_s;
    logic [NUM_PORTS-1:0]  grant_oh_s;
    logic                  expire_s;

    // Round-robin search: walk offsets downward so the nearest requester after rr_last wins.
    always_comb begin
        idx_s       = {GW{1'b0}};
        grant_s     = {GW{1'b0}};
        grant_vld_s = 1'b0;
        for (int i = NUM_PORTS; i >= 1; i--) begin
            idx_s = GW'((int'(rr_last_q) + i) % NUM_PORTS);
            if (in_req[idx_s]) begin
                grant_s     = idx_s;
                grant_vld_s = 1'b1;
            end else begin
                grant_vld_s = grant_vld_s;
            end
        end
    end

    // Watchdog compare and saturating next count.
    always_comb begin
        grant_oh_s = {{(NUM_PORTS-1){1'b0}}, 1'b1} << grant_q;
        expire_s   = (TIMEOUT_CYCLES > 0) && (cnt_q == TO_VAL);
        if (cnt_q == TO_VAL) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Transaction FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q            <= ST_IDLE;
            rr_last_q          <= RR_RESET;
            grant_q            <= {GW{1'b0}};
            cnt_q              <= {CW{1'b0}};
            out_valid_q        <= {NUM_PORTS{1'b0}};
            out_err_q          <= {NUM_PORTS{1'b0}};
            out_data_q         <= {DATA_WIDTH{1'b0}};
            out_mem_req_q      <= 1'b0;
            out_mem_addr_q     <= {ADDR_WIDTH{1'b0}};
            out_mem_data_q     <= {DATA_WIDTH{1'b0}};
            out_mem_acc_type_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    out_valid_q <= {NUM_PORTS{1'b0}};
                    out_err_q   <= {NUM_PORTS{1'b0}};
                    if (grant_vld_s) begin
                        grant_q            <= grant_s;
                        out_mem_addr_q     <= in_addr[grant_s*ADDR_WIDTH +: ADDR_WIDTH];
                        out_mem_data_q     <= in_data[grant_s*DATA_WIDTH +: DATA_WIDTH];
                        out_mem_acc_type_q <= in_mem_acc_type[grant_s];
                        out_mem_req_q      <= 1'b1;
                        state_q            <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    out_mem_req_q <= 1'b0;
                    cnt_q         <= {CW{1'b0}};
                    state_q       <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A response arriving on the expiry cycle still counts as good.
                    if (in_mem_valid) begin
                        out_data_q  <= in_mem_data;
                        out_valid_q <= grant_oh_s;
                        out_err_q   <= {NUM_PORTS{1'b0}};
                        state_q     <= ST_DONE;
                    end else if (expire_s) begin
                        out_data_q  <= {DATA_WIDTH{1'b0}};
                        out_valid_q <= grant_oh_s;
                        out_err_q   <= grant_oh_s;
                        state_q     <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                ST_DONE: begin
                    out_valid_q <= {NUM_PORTS{1'b0}};
                    out_err_q   <= {NUM_PORTS{1'b0}};
                    rr_last_q   <= grant_q;
                    state_q     <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_valid        = out_valid_q;
    assign out_err          = out_err_q;
    assign out_data         = out_data_q;
    assign out_mem_req      = out_mem_req_q;
    assign out_mem_addr     = out_mem_addr_q;
    assign out_mem_data     = out_mem_data_q;
    assign out_mem_acc_type = out_mem_acc_type_q;

endmodule

// File: tb/tb_snow64_mem_access_arbiter.sv
// Directed bench for snow64_mem_access_arbiter (4 ports, watchdog of 8 cycles).
module tb_snow64_mem_access_arbiter;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    in_req;
    logic [255:0]  in_addr;
    logic [1023:0] in_data;
    logic [3:0]    in_mem_acc_type;
    logic [3:0]    out_valid;
    logic [3:0]    out_err;
    logic [255:0]  out_data;
    logic          out_mem_req;
    logic [63:0]   out_mem_addr;
    logic [255:0]  out_mem_data;
    logic          out_mem_acc_type;
    logic          in_mem_valid;
    logic [255:0]  in_mem_data;

    int errors = 0;
    int checks = 0;

    snow64_mem_access_arbiter #(
        .NUM_PORTS(4), .ADDR_WIDTH(64), .DATA_WIDTH(256), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_req(in_req), .in_addr(in_addr),
        .in_data(in_data), .in_mem_acc_type(in_mem_acc_type),
        .out_valid(out_valid), .out_err(out_err), .out_data(out_data),
        .out_mem_req(out_mem_req), .out_mem_addr(out_mem_addr),
        .out_mem_data(out_mem_data), .out_mem_acc_type(out_mem_acc_type),
        .in_mem_valid(in_mem_valid), .in_mem_data(in_mem_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 256'(out_valid), 256'd0);
        chk({tag, "_err"}, 256'(out_err), 256'd0);
        chk({tag, "_data"}, out_data, 256'd0);
        chk({tag, "_mreq"}, 256'(out_mem_req), 256'd0);
        chk({tag, "_maddr"}, 256'(out_mem_addr), 256'd0);
        chk({tag, "_mdata"}, out_mem_data, 256'd0);
        chk({tag, "_mtype"}, 256'(out_mem_acc_type), 256'd0);
    endtask

    // Called in an IDLE cycle with in_req already driven; returns in the DONE cycle.
    task automatic run_txn(input string tag, input int ch, input int lat, input bit give_valid,
                           input logic [255:0] rdata, input bit exp_err);
        logic [3:0]  oh;
        logic [63:0] exp_addr;
        oh       = 4'b0001 << ch;
        exp_addr = in_addr[ch*64 +: 64];
        step;
        chk({tag, "_mem_req"}, 256'(out_mem_req), 256'd1);
        chk({tag, "_mem_addr"}, 256'(out_mem_addr), 256'(exp_addr));
        chk({tag, "_mem_data"}, out_mem_data, in_data[ch*256 +: 256]);
        chk({tag, "_mem_type"}, 256'(out_mem_acc_type), 256'(in_mem_acc_type[ch]));
        for (int i = 0; i < lat; i++) step;
        step;
        chk({tag, "_req_pulse"}, 256'(out_mem_req), 256'd0);
        chk({tag, "_no_early_valid"}, 256'(out_valid), 256'd0);
        if (give_valid) begin
            in_mem_valid = 1'b1;
            in_mem_data  = rdata;
        end
        step;
        in_mem_valid = 1'b0;
        in_mem_data  = {8{32'hDEAD_BEEF}};
        chk({tag, "_out_valid"}, 256'(out_valid), 256'(oh));
        chk({tag, "_out_err"}, 256'(out_err), exp_err ? 256'(oh) : 256'd0);
        chk({tag, "_out_data"}, out_data, give_valid ? rdata : 256'd0);
        chk({tag, "_addr_stable"}, 256'(out_mem_addr), 256'(exp_addr));
    endtask

    initial begin
        rst_n           = 1'b0;
        in_req          = 4'b0000;
        in_addr         = {64'h0000_0000_0000_0040, 64'h0000_0000_0000_1000,
                           64'h0000_0000_0000_0200, 64'h0000_0000_0000_0100};
        in_data         = {{32{8'h5A}}, {32{8'h33}}, {32{8'h22}}, {32{8'h11}}};
        in_mem_acc_type = 4'b1000;
        in_mem_valid    = 1'b0;
        in_mem_data     = 256'd0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;

        // 1: read on ch2, memory answers one cycle after the request.
        in_req = 4'b0100;
        run_txn("t1", 2, 0, 1'b1, {32{8'hAB}}, 1'b0);
        in_req = 4'b0000;
        step;

        // 4: ch0 read with no response -> watchdog error, stray valid later dropped.
        in_req = 4'b0001;
        run_txn("t4", 0, 8, 1'b0, 256'd0, 1'b1);
        in_req = 4'b0000;
        step;
        in_mem_valid = 1'b1;
        in_mem_data  = {32{8'hEE}};
        step;
        in_mem_valid = 1'b0;
        chk("t4_stray_valid", 256'(out_valid), 256'd0);
        chk("t4_stray_data", out_data, 256'd0);
        chk("t4_stray_mreq", 256'(out_mem_req), 256'd0);
        step;
        chk("t4_stray_valid2", 256'(out_valid), 256'd0);

        // 3: after ch1, ch1 and ch3 together -> ch3 then ch1.
        in_req = 4'b0010;
        run_txn("t3a", 1, 0, 1'b1, {8{32'h0000_1111}}, 1'b0);
        in_req = 4'b1010;
        step;
        run_txn("t3b", 3, 1, 1'b1, {8{32'h0000_3333}}, 1'b0);
        in_req = 4'b0010;
        step;
        run_txn("t3c", 1, 2, 1'b1, {8{32'h0000_1112}}, 1'b0);
        in_req = 4'b0000;
        step;

        // 6: write on ch3 whose response lands on the expiry cycle -> no error.
        in_req = 4'b1000;
        run_txn("t6", 3, 8, 1'b1, {32{8'h5A}}, 1'b0);
        in_req = 4'b0000;
        step;

        // 2: all channels requesting -> strict rotation 0,1,2,3,...
        in_req = 4'b1111;
        for (int k = 0; k < 16; k++) begin
            run_txn($sformatf("t2_%0d", k), k % 4, k % 3, 1'b1, {8{32'hC0DE_0000 + 32'(k)}}, 1'b0);
            if (k == 15) in_req = 4'b0000;
            step;
        end

        // 5: reset while ch1 waits; late valid ignored; ch0 then served first.
        in_req = 4'b0010;
        step;
        step;
        step;
        rst_n  = 1'b0;
        in_req = 4'b0000;
        #1;
        chk_all_zero("t5_rst");
        step;
        rst_n        = 1'b1;
        in_mem_valid = 1'b1;
        in_mem_data  = {32{8'h77}};
        step;
        in_mem_valid = 1'b0;
        chk("t5_late_valid", 256'(out_valid), 256'd0);
        chk("t5_late_data", out_data, 256'd0);
        chk("t5_late_mreq", 256'(out_mem_req), 256'd0);
        in_req = 4'b0011;
        run_txn("t5", 0, 0, 1'b1, {32{8'h99}}, 1'b0);
        in_req = 4'b0000;
        step;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
